// File: rtl/cache_pkg.sv
// Shared constants, FSM encodings and address helpers for the cache refill path.
package cache_pkg;

   localparam int unsigned TAG_W  = 6;
   localparam int unsigned LINE_W = 2;
   localparam int unsigned BLK_W  = 3;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = TAG_W + LINE_W + BLK_W;

   // Refill FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // RAM word address: {tag, line, word-in-block}
   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [LINE_W-1:0] line;
      logic [BLK_W-1:0]  blk;
   } mem_addr_t;

   // Assemble a RAM word address from its fields
   function automatic mem_addr_t make_addr(input logic [TAG_W-1:0]  tag,
                                           input logic [LINE_W-1:0] line,
                                           input logic [BLK_W-1:0]  blk);
      mem_addr_t a;
      a.tag  = tag;
      a.line = line;
      a.blk  = blk;
      return a;
   endfunction

   // Field slices of a flat address
   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [LINE_W-1:0] addr_line(input logic [ADDR_W-1:0] a);
      return a[BLK_W +: LINE_W];
   endfunction

   function automatic logic [BLK_W-1:0] addr_blk(input logic [ADDR_W-1:0] a);
      return a[BLK_W-1:0];
   endfunction

endpackage

// File: rtl/cache_refill_engine_counter.sv
// Word pointer for a block refill: loadable wrap-around word index plus a
// words-received count whose all-ones value flags the last word of the block.
module refill_counter
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BLK_W-1:0] start,
   input  logic             inc,
   output logic [BLK_W-1:0] word,
   output logic             first_c,
   output logic             last_c
);

   logic [BLK_W-1:0] count;

   // Word index wraps naturally at 2**BLK_W; count tracks words accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word  <= '0;
         count <= '0;
      end else if (load) begin
         word  <= start;
         count <= '0;
      end else if (inc) begin
         word  <= word + BLK_W'(1);
         count <= count + BLK_W'(1);
      end
   end

   assign first_c = (count == '0);
   assign last_c  = (count == '1);

endmodule

// File: rtl/cache_refill_engine.sv
// Miss-side refill engine: fetches an 8-word block from backing RAM one word
// at a time and streams each word into the cache data array, then pulses
// fill_done so the cache can write tag and valid.
// Optional feature macro: CRIT_WORD_FIRST_EN (start the burst at the missing
// word and flag it with crit_rdy). Default build fetches words 0..7.
module cache_refill_engine
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              miss_req,
   input  logic [TAG_W-1:0]  miss_tag,
   input  logic [LINE_W-1:0] miss_line,
   input  logic [BLK_W-1:0]  miss_blk,
   input  logic              abort,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              fill_wr,
   output logic [BLK_W-1:0]  fill_blk,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_done,
   output logic              crit_rdy,
   output logic              busy
);

   logic [1:0]        state;
   logic [1:0]        state_d;
   logic [TAG_W-1:0]  tag_q;
   logic [LINE_W-1:0] line_q;
   logic [BLK_W-1:0]  start_word;
   logic [BLK_W-1:0]  word;
   logic              first_c;
   logic              last_c;
   logic              start_c;
   logic              accept_c;
   logic              mem_rd_d;
   logic              fill_done_d;
   logic              busy_d;

`ifdef CRIT_WORD_FIRST_EN
   assign start_word = miss_blk;
`else
   logic unused_crit;
   assign start_word  = '0;
   assign unused_crit = ^{miss_blk, first_c};
`endif

   refill_counter u_counter (
      .clk     (clk),
      .reset   (reset),
      .load    (start_c),
      .start   (start_word),
      .inc     (accept_c),
      .word    (word),
      .first_c (first_c),
      .last_c  (last_c)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_d;
   end

   // Next state and next values of the registered outputs; abort beats everything
   always_comb begin
      state_d     = state;
      start_c     = 1'b0;
      accept_c    = 1'b0;
      mem_rd_d    = 1'b0;
      fill_done_d = 1'b0;
      busy_d      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (miss_req && !abort) begin
               state_d = ST_ISSUE;
               start_c = 1'b1;
            end
         end
         ST_ISSUE: begin
            state_d = abort ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (mem_valid) begin
               accept_c = 1'b1;
               state_d  = last_c ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      mem_rd_d    = (state_d == ST_ISSUE);
      fill_done_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // Capture the missing block's tag and line when a refill starts
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_q  <= '0;
         line_q <= '0;
      end else if (start_c) begin
         tag_q  <= miss_tag;
         line_q <= miss_line;
      end
   end

   // Registered handshake, fill and status outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_rd    <= 1'b0;
         fill_wr   <= 1'b0;
         fill_blk  <= '0;
         fill_data <= '0;
         fill_done <= 1'b0;
         busy      <= 1'b0;
      end else begin
         mem_rd    <= mem_rd_d;
         fill_wr   <= accept_c;
         fill_done <= fill_done_d;
         busy      <= busy_d;
         if (accept_c) begin
            fill_blk  <= word;
            fill_data <= mem_rdata;
         end
      end
   end

`ifdef CRIT_WORD_FIRST_EN
   // Flag the fill of the originally requested word (always the first one)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) crit_rdy <= 1'b0;
      else        crit_rdy <= accept_c && first_c;
   end
`else
   assign crit_rdy = 1'b0;
`endif

   // Address is held in flops for the whole ISSUE..WAIT window
   assign mem_addr = make_addr(tag_q, line_q, word);

endmodule
